// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with a built-in clear sequencer that zeroes every entry
// after reset and on request. Define REG_FILE_2R1W_BYPASS_EN for same-cycle write-to-read bypass.
module reg_file_2r1w #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr0,
  output logic [B-1:0] r_data0,
  input  logic [W-1:0] r_addr1,
  output logic [B-1:0] r_data1,
  input  logic         clr_req,
  output logic         busy
);

  localparam int unsigned Depth = 2 ** W;

  typedef enum logic {StClear, StIdle} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   clr_addr_q, clr_addr_d;
  logic [B-1:0]   mem_q [Depth];

  logic           mem_we;
  logic [W-1:0]   mem_waddr;
  logic [B-1:0]   mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StClear: begin
        if (&clr_addr_q) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + W'(1);
        end
      end
      StIdle: begin
        // clr_req only takes effect from idle, so a request mid-clear never extends it.
        if (clr_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = StClear;
        clr_addr_d = '0;
      end
    endcase
  end

  assign busy = (state_q == StClear);

  // The clear owns the write port while busy; rst_n gates it so reset never touches the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    if (rst_n) begin
      if (busy) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
      end else begin
        mem_we    = wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    r_data0 = '0;
    r_data1 = '0;
    if (!busy) begin
      r_data0 = mem_q[r_addr0];
      r_data1 = mem_q[r_addr1];
`ifdef REG_FILE_2R1W_BYPASS_EN
      if (wr_en && (r_addr0 == w_addr)) begin
        r_data0 = w_data;
      end
      if (wr_en && (r_addr1 == w_addr)) begin
        r_data1 = w_data;
      end
`endif
    end
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised register file with two independent asynchronous read ports and one synchronous write port. A built-in clear sequencer zeroes every entry after reset and on request. Intended as the general-purpose storage element for datapaths needing two operands per cycle, such as ALU operand fetch or FIFO/stack cores. Replaces the single-read-port, uninitialised register file.

Parameters:
B, 8, data width in bits (>=1)
W, 2, address width in bits (>=1); depth = 2**W entries

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe, sampled on rising clk edge
w_addr  in  W  write address
w_data  in  B  write data
r_addr0  in  W  read port 0 address
r_data0  out  B  read port 0 data (combinational)
r_addr1  in  W  read port 1 address
r_data1  out  B  read port 1 data (combinational)
clr_req  in  1  single-cycle request to zero all entries
busy  out  1  high while clear sequence running; writes ignored

Behaviour:
- Storage: 2**W x B array; no async reset on the array itself; contents defined only by the clear sequencer and writes.
- Clear FSM states: CLEAR, IDLE; counter clr_addr W bits.
- rst_n low (async): state=CLEAR, clr_addr=0, busy=1. While rst_n low no array writes occur.
- CLEAR: each rising edge writes 0 to array[clr_addr] and clr_addr increments. When clr_addr==2**W-1 that entry is written, then state->IDLE, clr_addr->0.
- After rst_n deasserts, busy stays high for exactly 2**W rising edges, then drops.
- IDLE: clr_req=1 -> CLEAR on next edge, clr_addr=0. busy rises the cycle after clr_req. No array write occurs on the request edge.
- clr_req while in CLEAR is ignored. The sequence does not restart or extend.
- rst_n asserted mid-clear: aborts the sequence. Clear restarts from entry 0 after release.
- Write: in IDLE with wr_en=1, array[w_addr] <= w_data on the rising edge. wr_en while busy=1 is dropped silently and is not queued.
- Simultaneous clr_req and wr_en in IDLE: the write completes on that edge, then the clear zeroes the whole array, including that entry.
- Read: r_dataN = array[r_addrN], zero latency. Both ports are fully independent and may use the same address.
- While busy=1, including during reset, r_data0 and r_data1 are forced to 0.
- Read and write to the same address in the same cycle (IDLE): the read returns the pre-write contents. The new value is visible the cycle after the edge. See the optional feature for the alternative.
- Address wrap: addresses are exactly W bits. No out-of-range case exists.

Optional Feature:
- Macro: REG_FILE_2R1W_BYPASS_EN.
- Defined: write-to-read bypass. When in IDLE with wr_en=1 and r_addrN==w_addr, r_dataN = w_data in the same cycle. This applies per port, independently.
- Not defined: read-during-write returns the old contents, as stated above.
- With the macro defined, bypass never applies while busy=1. Outputs remain forced to 0.

Test Plan:
- (B=8, W=2) Assert rst_n low, release at edge 0 -> busy=1 for 4 edges, then 0. r_data0/r_data1=0x00 for all 4 addresses afterwards.
- IDLE: write 0xA5 to addr 2 and 0x3C to addr 1. Next cycle r_addr0=2, r_addr1=1 -> r_data0=0xA5, r_data1=0x3C. Then both ports at addr 2 -> both 0xA5.
- Pulse clr_req after filling all 4 entries with 0xFF -> busy=1 for 4 cycles. Outputs read 0 during the sequence. All entries read 0x00 afterwards. A second clr_req at busy cycle 2 does not extend busy beyond 4 cycles.
- Assert wr_en with addr 3 / 0x77 while busy=1 -> after the clear completes, addr 3 reads 0x00.
- Same-cycle write of 0x5A to addr 0 with r_addr0=0 (old value 0x11) -> r_data0=0x11 without the macro, 0x5A with REG_FILE_2R1W_BYPASS_EN. Next cycle r_data0=0x5A in both builds.
- Pulse rst_n low for half a cycle at clear step 2 -> busy stays 1. After release busy lasts a full 4 edges again, and all entries read 0x00.
